// File: rtl/signed_add_arbiter_if.sv
// Handshake bundle between two operand requesters, the shared adder and the result consumer.
// The master drives requests and consumes results; the slave is the arbiter itself.
interface signed_add_arbiter_if #(
  parameter int W     = 4,
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [W-1:0]     req0_a;
  logic [W-1:0]     req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [W-1:0]     req1_a;
  logic [W-1:0]     req1_b;

  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_sum;
  logic             res_overflow;
  logic             res_id;
  logic [CNT_W-1:0] ovf_count;

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  res_valid, res_sum, res_overflow, res_id, ovf_count,
    output res_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output res_valid, res_sum, res_overflow, res_id, ovf_count,
    input  res_ready
  );
endinterface

// File: rtl/signed_add_arbiter.sv
// One W-bit two's-complement adder shared round-robin between two requesters,
// with a single-entry result register and a saturating overflow event counter.
module signed_add_arbiter #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  signed_add_arbiter_if.slave  bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             prio;
  logic [W-1:0]     sum_q;
  logic             ovf_q;
  logic             id_q;
  logic [CNT_W-1:0] cnt_q;

  logic             slot_free;
  logic             grant;
  logic             accept;
  logic [W-1:0]     a_sel;
  logic [W-1:0]     b_sel;
  logic [W-1:0]     sum;
  logic             overflow;

  // prio names the requester that wins the next tie
  always_comb begin
    slot_free = (state == EMPTY) || bus.res_ready;
    grant     = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      grant = prio;
    else if (bus.req1_valid)
      grant = 1'b1;
    a_sel    = grant ? bus.req1_a : bus.req0_a;
    b_sel    = grant ? bus.req1_b : bus.req0_b;
    sum      = a_sel + b_sel;
    overflow = (a_sel[W-1] == b_sel[W-1]) && (sum[W-1] != a_sel[W-1]);
  end

  // Readies are gated by rst_n so nothing is offered while reset is held
  assign bus.req0_ready = rst_n && slot_free && !grant;
  assign bus.req1_ready = rst_n && slot_free &&  grant;

  assign accept = (bus.req0_valid && bus.req0_ready) ||
                  (bus.req1_valid && bus.req1_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      prio  <= 1'b0;
      sum_q <= '0;
      ovf_q <= 1'b0;
      id_q  <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      state <= FULL;
      prio  <= ~grant;
      sum_q <= sum;
      ovf_q <= overflow;
      id_q  <= grant;
      if (overflow && (cnt_q != CNT_MAX))
        cnt_q <= cnt_q + CNT_W'(1);
    end else if (bus.res_ready) begin
      state <= EMPTY;
    end
  end

  assign bus.res_valid    = (state == FULL);
  assign bus.res_sum      = sum_q;
  assign bus.res_overflow = ovf_q;
  assign bus.res_id       = id_q;
  assign bus.ovf_count    = cnt_q;

endmodule

// File: tb/tb_signed_add_arbiter.sv
// Directed bench for signed_add_arbiter: an arithmetic reference model is checked every
// cycle, and hand-computed literal expectations are checked at chosen points.
module tb_signed_add_arbiter;

  localparam int W       = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int SMAX    = (1 << (W - 1)) - 1;
  localparam int SMIN    = -(1 << (W - 1));

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  signed_add_arbiter_if #(.W(W), .CNT_W(CNT_W)) bus ();

  signed_add_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vec_count  = 0;
  int miss_count = 0;

  // Reference model: result slot, last granted requester, event count as plain integers
  logic         m_valid;
  logic [W-1:0] m_sum;
  logic         m_ovf;
  logic         m_id;
  logic         m_last;
  int           m_cnt;

  logic         m_grant, m_free, m_rdy0, m_rdy1, m_take, m_ovf_next;
  logic [W-1:0] op_a, op_b;
  int           m_total;

  always_comb begin
    m_grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      m_grant = ~m_last;
    else if (bus.req1_valid)
      m_grant = 1'b1;
    m_free     = rst_n && (!m_valid || bus.res_ready);
    m_rdy0     = m_free && (m_grant == 1'b0);
    m_rdy1     = m_free && (m_grant == 1'b1);
    m_take     = (bus.req0_valid && m_rdy0) || (bus.req1_valid && m_rdy1);
    op_a       = m_grant ? bus.req1_a : bus.req0_a;
    op_b       = m_grant ? bus.req1_b : bus.req0_b;
    m_total    = int'($signed(op_a)) + int'($signed(op_b));
    m_ovf_next = (m_total > SMAX) || (m_total < SMIN);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_sum   <= '0;
      m_ovf   <= 1'b0;
      m_id    <= 1'b0;
      m_last  <= 1'b1;
      m_cnt   <= 0;
    end else if (m_take) begin
      m_valid <= 1'b1;
      m_sum   <= m_total[W-1:0];
      m_ovf   <= m_ovf_next;
      m_id    <= m_grant;
      m_last  <= m_grant;
      if (m_ovf_next && (m_cnt < CNT_MAX))
        m_cnt <= m_cnt + 1;
    end else if (bus.res_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Literal expectations posted by the stimulus process, consumed at the next falling edge
  string        lit_name;
  logic         lit_valid;
  logic [W-1:0] lit_sum;
  logic         lit_ovf;
  logic         lit_id;
  int           lit_cnt;
  logic         lit_chk_rdy;
  logic         lit_rdy0;
  logic         lit_rdy1;
  int           lit_req  = 0;
  int           lit_done = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cmp("res_valid",    32'(bus.res_valid),    32'(m_valid));
    cmp("req0_ready",   32'(bus.req0_ready),   32'(m_rdy0));
    cmp("req1_ready",   32'(bus.req1_ready),   32'(m_rdy1));
    cmp("res_sum",      32'(bus.res_sum),      32'(m_sum));
    cmp("res_overflow", 32'(bus.res_overflow), 32'(m_ovf));
    cmp("res_id",       32'(bus.res_id),       32'(m_id));
    cmp("ovf_count",    32'(bus.ovf_count),    32'(m_cnt));
    if (lit_req != lit_done) begin
      lit_done = lit_req;
      cmp({lit_name, ".valid"}, 32'(bus.res_valid),    32'(lit_valid));
      cmp({lit_name, ".sum"},   32'(bus.res_sum),      32'(lit_sum));
      cmp({lit_name, ".ovf"},   32'(bus.res_overflow), 32'(lit_ovf));
      cmp({lit_name, ".id"},    32'(bus.res_id),       32'(lit_id));
      cmp({lit_name, ".cnt"},   32'(bus.ovf_count),    32'(lit_cnt));
      if (lit_chk_rdy) begin
        cmp({lit_name, ".rdy0"}, 32'(bus.req0_ready), 32'(lit_rdy0));
        cmp({lit_name, ".rdy1"}, 32'(bus.req1_ready), 32'(lit_rdy1));
      end
    end
  end

  task automatic applyStimulus(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                               input logic rr);
    @(posedge clk);
    #1;
    bus.req0_valid = v0;
    bus.req0_a     = a0;
    bus.req0_b     = b0;
    bus.req1_valid = v1;
    bus.req1_a     = a1;
    bus.req1_b     = b1;
    bus.res_ready  = rr;
  endtask

  task automatic checkOutput(input string name, input logic valid, input logic [W-1:0] sum,
                             input logic ovf, input logic id, input int cnt,
                             input logic chk_rdy, input logic rdy0, input logic rdy1);
    lit_name    = name;
    lit_valid   = valid;
    lit_sum     = sum;
    lit_ovf     = ovf;
    lit_id      = id;
    lit_cnt     = cnt;
    lit_chk_rdy = chk_rdy;
    lit_rdy0    = rdy0;
    lit_rdy1    = rdy1;
    lit_req++;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.res_ready  = 1'b0;
    checkOutput("reset", 1'b0, 4'h0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 7 + 1 overflows to -8
    applyStimulus(1'b1, 4'b0111, 4'b0001, 1'b0, 4'h0, 4'h0, 1'b1);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
    checkOutput("r0_ovf", 1'b1, 4'b1000, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0);

    // -8 + -1 overflows to 7, then 3 + -2 = 1 without overflow
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'b1000, 4'b1111, 1'b1);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'b0011, 4'b1110, 1'b1);
    checkOutput("r1_neg_ovf", 1'b1, 4'b0111, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
    checkOutput("r1_no_ovf", 1'b1, 4'b0001, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0);

    // Both requesters continuously: grants alternate, one result per cycle
    applyStimulus(1'b1, 4'd1, 4'd1, 1'b1, 4'd2, 4'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < 3)
        applyStimulus(1'b1, 4'd1, 4'd1, 1'b1, 4'd2, 4'd2, 1'b1);
      else
        applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
      checkOutput($sformatf("rr_%0d", i), 1'b1, (i % 2 == 1) ? 4'd4 : 4'd2, 1'b0,
                  1'(i % 2), 2, (i < 3), (i % 2 == 1), (i % 2 == 0));
    end

    // Back-pressure: result held for 3 cycles, then drains and accepts in the same cycle
    applyStimulus(1'b1, 4'd3, 4'd3, 1'b0, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'd5, 4'd5, 1'b1, 4'd6, 4'd6, 1'b0);
      checkOutput($sformatf("hold_%0d", i), 1'b1, 4'd6, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 4'd5, 4'd5, 1'b1, 4'd6, 4'd6, 1'b1);
    checkOutput("hold_release", 1'b1, 4'd6, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
    checkOutput("after_drain", 1'b1, 4'b1100, 1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0);

    // Counter saturation: 7 + 7 overflows every cycle
    for (int k = 1; k <= 260; k++) begin
      applyStimulus(1'b1, 4'd7, 4'd7, 1'b0, 4'h0, 4'h0, 1'b1);
      if (k == 252)
        checkOutput("sat_254", 1'b1, 4'b1110, 1'b1, 1'b0, 254, 1'b1, 1'b1, 1'b0);
      if (k == 253)
        checkOutput("sat_255", 1'b1, 4'b1110, 1'b1, 1'b0, 255, 1'b1, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
    checkOutput("sat_hold", 1'b1, 4'b1110, 1'b1, 1'b0, 255, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset while FULL
    applyStimulus(1'b1, 4'd1, 4'd2, 1'b0, 4'h0, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    #2 rst_n = 1'b0;
    checkOutput("reset_mid", 1'b0, 4'h0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 4'd1, 4'd1, 1'b1, 4'd2, 4'd2, 1'b1);
    checkOutput("post_reset_tie", 1'b0, 4'h0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
    checkOutput("post_reset_res", 1'b1, 4'd2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
